// File: rtl/stage_sequencer_if.sv
// Program-load stream (valid/ready) and program-memory write port of the stage sequencer.
// master = load source / memory side, slave = sequencer.
interface stage_sequencer_if #(
    parameter int INSTR_W = 12,
    parameter int ADDR_W  = 8
);
    logic               load_valid;
    logic [INSTR_W-1:0] load_data;
    logic               load_last;
    logic               load_ready;
    logic               pmem_we;
    logic [ADDR_W-1:0]  pmem_addr;
    logic [INSTR_W-1:0] pmem_wdata;

    modport master (
        output load_valid, load_data, load_last,
        input  load_ready, pmem_we, pmem_addr, pmem_wdata
    );

    modport slave (
        input  load_valid, load_data, load_last,
        output load_ready, pmem_we, pmem_addr, pmem_wdata
    );
endinterface

// File: rtl/stage_sequencer.sv
// Processor stage sequencer: program load, then FETCH/DECODE/EXECUTE with run/halt/step (STAGE_SEQ_INSTR_CNT_EN adds `retired`).
// Latency: load writes are combinational (zero cycle); each instruction takes 3 cycles, HALT decisions at instruction boundaries.
// Backpressure: load_ready is high only in LOAD; beats offered in any other state are not accepted.
module stage_sequencer #(
    parameter int INSTR_W    = 12,
    parameter int ADDR_W     = 8,
    parameter int PMEM_DEPTH = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    stage_sequencer_if.slave  ld,
    input  logic              run_en,
    input  logic              step_req,
    input  logic              halt_req,
    input  logic              reload_req,
    output logic [1:0]        stage,
    output logic              core_en,
    output logic              halted,
`ifdef STAGE_SEQ_INSTR_CNT_EN
    output logic [15:0]       retired,
`endif
    output logic [ADDR_W:0]   load_count
);
    localparam logic [2:0] S_LOAD   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_HALT   = 3'd4;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PMEM_DEPTH - 1);
    localparam logic [ADDR_W:0]   MAX_CNT   = (ADDR_W + 1)'(PMEM_DEPTH);

    logic [2:0]         state_q, state_d;
    logic [ADDR_W-1:0]  load_ptr_q, load_ptr_d;
    logic [ADDR_W:0]    load_count_q, load_count_d;
    logic               step_mode_q, step_mode_d;
    logic               load_acc;
    logic [INSTR_W-1:0] wdata;

    assign ld.load_ready = (state_q == S_LOAD);
    assign load_acc      = ld.load_valid & ld.load_ready;
    assign wdata         = ld.load_data;
    assign ld.pmem_we    = load_acc;
    assign ld.pmem_addr  = load_ptr_q;
    assign ld.pmem_wdata = wdata;

    assign core_en    = (state_q == S_FETCH) || (state_q == S_DECODE) || (state_q == S_EXEC);
    assign halted     = (state_q == S_HALT);
    assign load_count = load_count_q;

    // HALT shares the FETCH encoding so the control unit's decode sees a stable stage.
    always_comb begin
        stage = 2'b00;
        case (state_q)
            S_FETCH:  stage = 2'b01;
            S_DECODE: stage = 2'b10;
            S_EXEC:   stage = 2'b11;
            S_HALT:   stage = 2'b01;
            default:  stage = 2'b00;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        load_ptr_d   = load_ptr_q;
        load_count_d = load_count_q;
        step_mode_d  = step_mode_q;
        case (state_q)
            S_LOAD: begin
                if (load_acc) begin
                    // Pointer parks at the last address so it never wraps.
                    if (load_ptr_q != LAST_ADDR)
                        load_ptr_d = load_ptr_q + 1'b1;
                    if (load_count_q != MAX_CNT)
                        load_count_d = load_count_q + 1'b1;
                    if (ld.load_last || (load_ptr_q == LAST_ADDR))
                        state_d = run_en ? S_FETCH : S_HALT;
                end
            end
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
                if (halt_req || !run_en || step_mode_q)
                    state_d = S_HALT;
                else
                    state_d = S_FETCH;
            end
            S_HALT: begin
                if (reload_req) begin
                    state_d      = S_LOAD;
                    load_ptr_d   = '0;
                    load_count_d = '0;
                end else if (run_en) begin
                    state_d     = S_FETCH;
                    step_mode_d = 1'b0;
                end else if (step_req) begin
                    state_d     = S_FETCH;
                    step_mode_d = 1'b1;
                end
            end
            default: state_d = S_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_LOAD;
            load_ptr_q   <= '0;
            load_count_q <= '0;
            step_mode_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            load_ptr_q   <= load_ptr_d;
            load_count_q <= load_count_d;
            step_mode_q  <= step_mode_d;
        end
    end

`ifdef STAGE_SEQ_INSTR_CNT_EN
    logic [15:0] retired_q, retired_d;

    always_comb begin
        retired_d = retired_q;
        if ((state_q == S_EXEC) && (retired_q != 16'hFFFF))
            retired_d = retired_q + 16'd1;
        if ((state_q == S_HALT) && reload_req)
            retired_d = 16'd0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            retired_q <= 16'd0;
        else
            retired_q <= retired_d;
    end

    assign retired = retired_q;
`endif
endmodule

// File: tb/tb_stage_sequencer.sv
// Directed bench for stage_sequencer: main instance (PMEM_DEPTH=256) plus a PMEM_DEPTH=4 instance for the depth limit.
module tb_stage_sequencer;
    logic clk = 1'b0;
    logic rst_n;
    logic run_en, step_req, halt_req, reload_req;

    logic [1:0] m_stage, s_stage;
    logic       m_core_en, s_core_en, m_halted, s_halted;
    logic [8:0] m_load_count, s_load_count;
`ifdef STAGE_SEQ_INSTR_CNT_EN
    logic [15:0] m_retired, s_retired;
`endif

    int vecs   = 0;
    int miscmp = 0;

    stage_sequencer_if #(.INSTR_W(12), .ADDR_W(8)) m_if ();
    stage_sequencer_if #(.INSTR_W(12), .ADDR_W(8)) s_if ();

    stage_sequencer #(.INSTR_W(12), .ADDR_W(8), .PMEM_DEPTH(256)) u_main (
        .clk(clk), .rst_n(rst_n), .ld(m_if.slave),
        .run_en(run_en), .step_req(step_req), .halt_req(halt_req), .reload_req(reload_req),
        .stage(m_stage), .core_en(m_core_en), .halted(m_halted),
`ifdef STAGE_SEQ_INSTR_CNT_EN
        .retired(m_retired),
`endif
        .load_count(m_load_count)
    );

    stage_sequencer #(.INSTR_W(12), .ADDR_W(8), .PMEM_DEPTH(4)) u_small (
        .clk(clk), .rst_n(rst_n), .ld(s_if.slave),
        .run_en(run_en), .step_req(step_req), .halt_req(halt_req), .reload_req(reload_req),
        .stage(s_stage), .core_en(s_core_en), .halted(s_halted),
`ifdef STAGE_SEQ_INSTR_CNT_EN
        .retired(s_retired),
`endif
        .load_count(s_load_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic run);
        rst_n = 1'b0;
        run_en = run; step_req = 1'b0; halt_req = 1'b0; reload_req = 1'b0;
        m_if.load_valid = 1'b0; m_if.load_data = '0; m_if.load_last = 1'b0;
        s_if.load_valid = 1'b0; s_if.load_data = '0; s_if.load_last = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset(1'b0);
        #1;
        vecs++; if (m_stage !== 2'b00) begin miscmp++; $display("FAIL reset_stage got %b want 00", m_stage); end
        vecs++; if (m_core_en !== 1'b0) begin miscmp++; $display("FAIL reset_core_en got %b want 0", m_core_en); end
        vecs++; if (m_halted !== 1'b0) begin miscmp++; $display("FAIL reset_halted got %b want 0", m_halted); end
        vecs++; if (m_if.load_ready !== 1'b1) begin miscmp++; $display("FAIL reset_load_ready got %b want 1", m_if.load_ready); end
        vecs++; if (m_if.pmem_we !== 1'b0) begin miscmp++; $display("FAIL reset_pmem_we got %b want 0", m_if.pmem_we); end
        vecs++; if (m_load_count !== 9'd0) begin miscmp++; $display("FAIL reset_load_count got %0d want 0", m_load_count); end
`ifdef STAGE_SEQ_INSTR_CNT_EN
        vecs++; if (m_retired !== 16'd0) begin miscmp++; $display("FAIL reset_retired got %0d want 0", m_retired); end
`endif
    endtask

    task automatic test_load_run();
        logic [11:0] beats [3];
        logic [1:0]  exp_stage [4];
        beats     = '{12'h101, 12'h202, 12'h3FF};
        exp_stage = '{2'b01, 2'b10, 2'b11, 2'b01};
        do_reset(1'b1);
        for (int i = 0; i < 3; i++) begin
            m_if.load_valid = 1'b1;
            m_if.load_data  = beats[i];
            m_if.load_last  = (i == 2);
            #1;
            vecs++; if (m_if.pmem_we !== 1'b1) begin miscmp++; $display("FAIL load_we[%0d] got %b want 1", i, m_if.pmem_we); end
            vecs++; if (m_if.pmem_addr !== 8'(i)) begin miscmp++; $display("FAIL load_addr[%0d] got %0d want %0d", i, m_if.pmem_addr, i); end
            vecs++; if (m_if.pmem_wdata !== beats[i]) begin miscmp++; $display("FAIL load_wdata[%0d] got %h want %h", i, m_if.pmem_wdata, beats[i]); end
            tick();
        end
        m_if.load_valid = 1'b0;
        m_if.load_last  = 1'b0;
        #1;
        vecs++; if (m_load_count !== 9'd3) begin miscmp++; $display("FAIL run_load_count got %0d want 3", m_load_count); end
        vecs++; if (m_if.load_ready !== 1'b0) begin miscmp++; $display("FAIL run_load_ready got %b want 0", m_if.load_ready); end
        for (int c = 0; c < 4; c++) begin
            vecs++; if (m_stage !== exp_stage[c]) begin miscmp++; $display("FAIL run_stage[%0d] got %b want %b", c, m_stage, exp_stage[c]); end
            vecs++; if (m_core_en !== 1'b1) begin miscmp++; $display("FAIL run_core_en[%0d] got %b want 1", c, m_core_en); end
            tick();
        end
    endtask

    task automatic test_step();
        logic [1:0] exp_stage [3];
        exp_stage = '{2'b01, 2'b10, 2'b11};
        do_reset(1'b0);
        for (int i = 0; i < 2; i++) begin
            m_if.load_valid = 1'b1; m_if.load_data = 12'h0C0 + 12'(i); m_if.load_last = (i == 1);
            tick();
        end
        m_if.load_valid = 1'b0; m_if.load_last = 1'b0;
        #1;
        vecs++; if (m_halted !== 1'b1) begin miscmp++; $display("FAIL halt_after_load got %b want 1", m_halted); end
        vecs++; if (m_stage !== 2'b01) begin miscmp++; $display("FAIL halt_stage got %b want 01", m_stage); end
        vecs++; if (m_core_en !== 1'b0) begin miscmp++; $display("FAIL halt_core_en got %b want 0", m_core_en); end
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        for (int c = 0; c < 3; c++) begin
            vecs++; if (m_stage !== exp_stage[c]) begin miscmp++; $display("FAIL step_stage[%0d] got %b want %b", c, m_stage, exp_stage[c]); end
            vecs++; if (m_halted !== 1'b0) begin miscmp++; $display("FAIL step_halted[%0d] got %b want 0", c, m_halted); end
            tick();
        end
        vecs++; if (m_halted !== 1'b1) begin miscmp++; $display("FAIL step_rehalt got %b want 1", m_halted); end
        vecs++; if (m_core_en !== 1'b0) begin miscmp++; $display("FAIL step_rehalt_core_en got %b want 0", m_core_en); end
`ifdef STAGE_SEQ_INSTR_CNT_EN
        vecs++; if (m_retired !== 16'd1) begin miscmp++; $display("FAIL step_retired got %0d want 1", m_retired); end
`endif
        tick();
        vecs++; if (m_halted !== 1'b1) begin miscmp++; $display("FAIL step_stays_halted got %b want 1", m_halted); end
    endtask

    task automatic test_halt();
        // Continues from HALT left by test_step.
        run_en = 1'b1;
        tick();
        vecs++; if (m_stage !== 2'b01 || m_core_en !== 1'b1) begin miscmp++; $display("FAIL resume_fetch got stage %b en %b want 01 1", m_stage, m_core_en); end
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        tick();
        vecs++; if (m_stage !== 2'b11) begin miscmp++; $display("FAIL early_pulse_exec got %b want 11", m_stage); end
        tick();
        vecs++; if (m_halted !== 1'b0 || m_stage !== 2'b01) begin miscmp++; $display("FAIL early_pulse_ignored got halted %b stage %b want 0 01", m_halted, m_stage); end
        tick();
        vecs++; if (m_stage !== 2'b10) begin miscmp++; $display("FAIL halt_decode got %b want 10", m_stage); end
        halt_req = 1'b1;
        tick();
        vecs++; if (m_stage !== 2'b11) begin miscmp++; $display("FAIL halt_exec_completes got %b want 11", m_stage); end
        tick();
        vecs++; if (m_halted !== 1'b1) begin miscmp++; $display("FAIL halt_taken got %b want 1", m_halted); end
        vecs++; if (m_core_en !== 1'b0) begin miscmp++; $display("FAIL halt_core_en got %b want 0", m_core_en); end
        halt_req = 1'b0;
        tick();
        vecs++; if (m_halted !== 1'b0 || m_stage !== 2'b01 || m_core_en !== 1'b1) begin
            miscmp++; $display("FAIL halt_release got halted %b stage %b en %b want 0 01 1", m_halted, m_stage, m_core_en);
        end
    endtask

    task automatic test_depth_limit();
        int writes;
        writes = 0;
        do_reset(1'b0);
        s_if.load_valid = 1'b1;
        s_if.load_last  = 1'b0;
        for (int i = 0; i < 6; i++) begin
            s_if.load_data = 12'h0A0 + 12'(i);
            #1;
            if (s_if.pmem_we === 1'b1) writes++;
            if (i < 4) begin
                vecs++; if (s_if.pmem_we !== 1'b1 || s_if.pmem_addr !== 8'(i)) begin
                    miscmp++; $display("FAIL depth_write[%0d] got we %b addr %0d want 1 %0d", i, s_if.pmem_we, s_if.pmem_addr, i);
                end
            end else begin
                vecs++; if (s_if.pmem_we !== 1'b0 || s_if.load_ready !== 1'b0) begin
                    miscmp++; $display("FAIL depth_blocked[%0d] got we %b rdy %b want 0 0", i, s_if.pmem_we, s_if.load_ready);
                end
            end
            tick();
        end
        s_if.load_valid = 1'b0;
        #1;
        vecs++; if (writes != 4) begin miscmp++; $display("FAIL depth_writes got %0d want 4", writes); end
        vecs++; if (s_load_count !== 9'd4) begin miscmp++; $display("FAIL depth_load_count got %0d want 4", s_load_count); end
        vecs++; if (s_halted !== 1'b1) begin miscmp++; $display("FAIL depth_halted got %b want 1", s_halted); end
    endtask

    task automatic test_reload_priority();
        do_reset(1'b0);
        m_if.load_valid = 1'b1; m_if.load_data = 12'h555; m_if.load_last = 1'b1;
        tick();
        m_if.load_valid = 1'b0; m_if.load_last = 1'b0;
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        tick(); tick(); tick();
        vecs++; if (m_halted !== 1'b1 || m_load_count !== 9'd1) begin
            miscmp++; $display("FAIL pre_reload got halted %b count %0d want 1 1", m_halted, m_load_count);
        end
        reload_req = 1'b1; run_en = 1'b1; step_req = 1'b1;
        tick();
        reload_req = 1'b0; run_en = 1'b0; step_req = 1'b0;
        #1;
        vecs++; if (m_stage !== 2'b00) begin miscmp++; $display("FAIL reload_stage got %b want 00", m_stage); end
        vecs++; if (m_load_count !== 9'd0) begin miscmp++; $display("FAIL reload_count got %0d want 0", m_load_count); end
        vecs++; if (m_if.load_ready !== 1'b1 || m_halted !== 1'b0) begin
            miscmp++; $display("FAIL reload_ready got rdy %b halted %b want 1 0", m_if.load_ready, m_halted);
        end
`ifdef STAGE_SEQ_INSTR_CNT_EN
        vecs++; if (m_retired !== 16'd0) begin miscmp++; $display("FAIL reload_retired got %0d want 0", m_retired); end
`endif
        for (int i = 0; i < 2; i++) begin
            m_if.load_valid = 1'b1; m_if.load_data = 12'h700 + 12'(i); m_if.load_last = (i == 1);
            #1;
            vecs++; if (m_if.pmem_we !== 1'b1 || m_if.pmem_addr !== 8'(i)) begin
                miscmp++; $display("FAIL reload_write[%0d] got we %b addr %0d want 1 %0d", i, m_if.pmem_we, m_if.pmem_addr, i);
            end
            tick();
        end
        m_if.load_valid = 1'b0; m_if.load_last = 1'b0;
        #1;
        vecs++; if (m_load_count !== 9'd2 || m_halted !== 1'b1) begin
            miscmp++; $display("FAIL reload_done got count %0d halted %b want 2 1", m_load_count, m_halted);
        end
    endtask

    task automatic test_mid_reset();
        do_reset(1'b1);
        m_if.load_valid = 1'b1; m_if.load_data = 12'h111; m_if.load_last = 1'b1;
        tick();
        m_if.load_valid = 1'b0; m_if.load_last = 1'b0;
        tick(); tick();
        vecs++; if (m_stage !== 2'b11) begin miscmp++; $display("FAIL pre_reset_exec got %b want 11", m_stage); end
        rst_n = 1'b0;
        tick();
        vecs++; if (m_stage !== 2'b00 || m_core_en !== 1'b0 || m_if.load_ready !== 1'b1) begin
            miscmp++; $display("FAIL exec_reset got stage %b en %b rdy %b want 00 0 1", m_stage, m_core_en, m_if.load_ready);
        end
        rst_n = 1'b1; run_en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_if.load_valid = 1'b1; m_if.load_data = 12'h900 + 12'(i); m_if.load_last = 1'b0;
            #1;
            vecs++; if (m_if.pmem_addr !== 8'(i)) begin miscmp++; $display("FAIL after_reset_addr[%0d] got %0d want %0d", i, m_if.pmem_addr, i); end
            tick();
        end
        m_if.load_valid = 1'b0;
        #1;
        vecs++; if (m_load_count !== 9'd2) begin miscmp++; $display("FAIL mid_load_count got %0d want 2", m_load_count); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        vecs++; if (m_stage !== 2'b00 || m_core_en !== 1'b0 || m_if.load_ready !== 1'b1 || m_load_count !== 9'd0) begin
            miscmp++; $display("FAIL load_reset got stage %b en %b rdy %b count %0d want 00 0 1 0", m_stage, m_core_en, m_if.load_ready, m_load_count);
        end
        m_if.load_valid = 1'b1; m_if.load_data = 12'hABC;
        #1;
        vecs++; if (m_if.pmem_we !== 1'b1 || m_if.pmem_addr !== 8'd0) begin
            miscmp++; $display("FAIL restart_addr got we %b addr %0d want 1 0", m_if.pmem_we, m_if.pmem_addr);
        end
        tick();
        m_if.load_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_load_run();
        test_step();
        test_halt();
        test_depth_limit();
        test_reload_priority();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
        $finish;
    end
endmodule

// File: doc/stage_sequencer.md
Name: stage_sequencer

Overview:
- Generates the 2-bit processor stage (LOAD/FETCH/DECODE/EXECUTE) that drives the control unit's decode.
- Owns the program-memory load port: accepts a valid/ready instruction stream at power-up or on reload and writes it into program memory.
- Provides run, halt and single-step control at instruction boundaries.
- `core_en` gates every datapath enable from the control unit at the top level.

Parameters:
- INSTR_W, 12, instruction word width.
- ADDR_W, 8, program-memory address width.
- PMEM_DEPTH, 256, number of program words; the last legal address is PMEM_DEPTH-1.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous reset, active-low
- load_valid  in  1  load word present
- load_data  in  INSTR_W  instruction word to store
- load_last  in  1  marks final word of program
- load_ready  out  1  sequencer accepts load word
- pmem_we  out  1  program-memory write strobe
- pmem_addr  out  ADDR_W  program-memory write address
- pmem_wdata  out  INSTR_W  program-memory write data
- run_en  in  1  level: free-run when high
- step_req  in  1  pulse: execute one instruction from HALT
- halt_req  in  1  pulse/level: stop at next instruction boundary
- reload_req  in  1  pulse: return to LOAD from HALT
- stage  out  2  00 LOAD, 01 FETCH, 10 DECODE, 11 EXECUTE
- core_en  out  1  datapath enable qualifier
- halted  out  1  high in HALT state
- load_count  out  ADDR_W+1  words written in current/last load

Behaviour:
- States: LOAD, FETCH, DECODE, EXECUTE, HALT.
- Reset, sampled on the clk edge with rst_n low:
  - state=LOAD, load_ptr=0, load_count=0, step_mode=0.
  - Outputs: stage=00, core_en=0, halted=0, load_ready=1, pmem_we=0.
- Reset mid-load or mid-instruction aborts the operation at that edge. Loading restarts at address 0. Memory contents are not cleared.
- LOAD state:
  - stage=00, core_en=0, load_ready=1.
  - Write path is combinational, zero latency: pmem_we = load_valid & load_ready, pmem_addr = load_ptr, pmem_wdata = load_data.
  - Each accepted beat increments load_ptr and load_count at the clock edge.
  - Load ends after a beat with load_last=1, or the beat written at PMEM_DEPTH-1, whichever comes first. Later words are never written and the address never wraps.
  - Next state on end of load: FETCH if run_en=1, else HALT.
- FETCH, DECODE and EXECUTE:
  - stage = 01 / 10 / 11 respectively; core_en=1, load_ready=0, pmem_we=0.
  - FETCH->DECODE->EXECUTE advances unconditionally, one cycle each; each instruction takes exactly 3 cycles.
- Leaving EXECUTE:
  - To HALT if halt_req=1, run_en=0, or step_mode=1.
  - Otherwise to FETCH.
  - halt_req asserted during FETCH/DECODE takes effect only when sampled in EXECUTE. A pulse that lands entirely before EXECUTE is ignored; requesters hold it until `halted`.
- HALT state:
  - stage=01, core_en=0, halted=1, load_ready=0.
  - Priority: reload_req (-> LOAD, load_ptr=0, load_count=0) > run_en (-> FETCH, step_mode=0) > step_req (-> FETCH, step_mode=1).
  - step_req held high re-steps once per 4-cycle round trip (HALT, FETCH, DECODE, EXECUTE).
- reload_req outside HALT is ignored.
- step_req and run_en sampled outside HALT have no effect beyond the EXECUTE exit rule.
- load_count saturates at PMEM_DEPTH and is held until the next entry to LOAD.

Optional Feature:
- Macro: STAGE_SEQ_INSTR_CNT_EN.
- With the macro defined:
  - Adds output `retired` (16 bits), incremented on every EXECUTE cycle.
  - Saturates at 0xFFFF.
  - Cleared by reset and on entry to LOAD.
- Without the macro: the port and counter are absent. All other behaviour is identical.

Test Plan:
1. Reset with run_en=1; send 3 beats 0x101, 0x202, 0x3FF (last on third) with load_valid held -> pmem_we high 3 cycles at addr 0, 1, 2. stage then 01, 10, 11, 01… from the 4th cycle; core_en=1; load_count=3.
2. Load with run_en=0; ends in HALT (halted=1, stage=01, core_en=0). Pulse step_req -> exactly one 01, 10, 11 sequence, then halted=1 again. With STAGE_SEQ_INSTR_CNT_EN defined, retired=1.
3. Free-run; pulse halt_req during DECODE and hold until halted -> current EXECUTE completes, next cycle halted=1. Deassert halt_req and keep run_en=1 -> FETCH on the following cycle.
4. PMEM_DEPTH=4; stream 6 beats with load_last never set -> exactly 4 writes (addr 0–3), load_ready=0 afterwards, load_count=4.
5. In HALT, assert reload_req, run_en and step_req in the same cycle -> LOAD entered, stage=00, load_count=0. A new 2-beat load writes addr 0 and 1.
6. Drop rst_n for one cycle during EXECUTE and separately mid-load after 2 beats -> both return to stage=00, core_en=0, load_ready=1. The next accepted beat is written to addr 0.
